// File: rtl/gray_input_sync.sv
// gray_input_sync
//   Front-end for the Gray-to-7-segment decoder. Each raw board input is
//   passed through a two-flop synchroniser. The four switches are then
//   debounced as one group, and the button is debounced on its own path.
//   A value is committed only after it has been stable for DEBOUNCE_CYCLES
//   synchronised cycles.
//
//   Build option: define GRAY_CHECK_EN to implement the sticky gray_err
//   check. Without it, gray_err is tied low and the port is kept.
//
// Ports
//   clk      in   system clock; all logic is on the rising edge
//   rst_n    in   synchronous, active-low reset
//   sw_in    in   [3:0] raw asynchronous Gray-code switches
//   btn_in   in   raw asynchronous digit-select button
//   s        out  [3:0] debounced Gray code, to the decoder s input
//   bot      out  debounced button level, to the decoder bot input
//   s_valid  out  one-cycle pulse when a new s is committed
//   gray_err out  sticky: a committed s changed in more than one bit
module gray_input_sync #(
  parameter int  DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_in,
  input  logic       btn_in,
  output logic [3:0] s,
  output logic       bot,
  output logic       s_valid,
  output logic       gray_err
);

  // The stability timers count down. Reloading on a change and committing
  // at zero gives the same number of stable cycles as counting up to
  // DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       sw_meta;
  logic [3:0]       sw_sync;
  logic             btn_meta;
  logic             btn_sync;

  logic [3:0]       cand_sw;
  logic [CNT_W-1:0] cnt_sw;
  logic             cand_btn;
  logic [CNT_W-1:0] cnt_btn;

  logic             sw_commit;
  logic             btn_commit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sw_meta  <= sw_in;
      sw_sync  <= sw_meta;
      btn_meta <= btn_in;
      btn_sync <= btn_meta;
    end
  end

  // A commit needs the candidate still stable, the timer expired, and a
  // value that differs from the one presented. The last term keeps a
  // bounce that settles back to the current s from pulsing s_valid.
  assign sw_commit  = (sw_sync == cand_sw) && (cnt_sw == '0) && (cand_sw != s);
  assign btn_commit = (btn_sync == cand_btn) && (cnt_btn == '0) && (cand_btn != bot);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_sw <= '0;
      cnt_sw  <= '0;
      s       <= '0;
      s_valid <= 1'b0;
    end else begin
      s_valid <= 1'b0;
      if (sw_sync != cand_sw) begin
        cand_sw <= sw_sync;
        cnt_sw  <= CNT_LOAD;
      end else if (cnt_sw != '0) begin
        cnt_sw <= cnt_sw - CNT_ONE;
      end else if (sw_commit) begin
        s       <= cand_sw;
        s_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_btn <= 1'b0;
      cnt_btn  <= '0;
      bot      <= 1'b0;
    end else begin
      if (btn_sync != cand_btn) begin
        cand_btn <= btn_sync;
        cnt_btn  <= CNT_LOAD;
      end else if (cnt_btn != '0) begin
        cnt_btn <= cnt_btn - CNT_ONE;
      end else if (btn_commit) begin
        bot <= cand_btn;
      end
    end
  end

`ifdef GRAY_CHECK_EN
  logic [3:0] sw_diff;
  logic       multi_bit;

  // x & (x-1) clears the lowest set bit; anything left means two or more
  // bits changed between the old and the new code.
  assign sw_diff   = s ^ cand_sw;
  assign multi_bit = (sw_diff & (sw_diff - 4'd1)) != 4'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gray_err <= 1'b0;
    end else if (sw_commit && multi_bit) begin
      gray_err <= 1'b1;
    end
  end
`else
  assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_input_sync.sv
module tb_gray_input_sync;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_in;
  logic       btn_in;
  logic [3:0] s;
  logic       bot;
  logic       s_valid;
  logic       gray_err;

  int total;
  int bad;

`ifdef GRAY_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  typedef struct {
    logic [3:0] sw;
    logic       btn;
    logic [3:0] exp_s;
    logic       exp_bot;
    int         exp_pulses;
    logic       exp_err;
  } vec_t;

  vec_t vecs[10];

  logic [3:0] cur_s;
  logic       cur_bot;

  gray_input_sync #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_in    (sw_in),
    .btn_in   (btn_in),
    .s        (s),
    .bot      (bot),
    .s_valid  (s_valid),
    .gray_err (gray_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector, hold it 10 cycles, check hold at edge 6 and commit at
  // edge 7, then the pulse count and the sticky flag.
  task automatic apply_vec(input int idx, input vec_t v);
    int pulses;
    pulses = 0;
    sw_in  = v.sw;
    btn_in = v.btn;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (s_valid === 1'b1) pulses++;
      if (k == 6) begin
        check($sformatf("v%0d s_before", idx), int'(s), int'(cur_s));
        check($sformatf("v%0d bot_before", idx), int'(bot), int'(cur_bot));
      end
      if (k == 7) begin
        check($sformatf("v%0d s_edge7", idx), int'(s), int'(v.exp_s));
        check($sformatf("v%0d bot_edge7", idx), int'(bot), int'(v.exp_bot));
        check($sformatf("v%0d valid_edge7", idx), int'(s_valid), v.exp_pulses);
      end
    end
    check($sformatf("v%0d pulses", idx), pulses, v.exp_pulses);
    check($sformatf("v%0d gray_err", idx), int'(gray_err), int'(v.exp_err));
    cur_s   = v.exp_s;
    cur_bot = v.exp_bot;
  endtask

  // Short excursion of `len` cycles that returns to 0001; nothing commits.
  task automatic glitch(input string name, input int len);
    int pulses;
    int s_moved;
    pulses  = 0;
    s_moved = 0;
    sw_in   = 4'b0011;
    for (int k = 0; k < len; k++) begin
      tick();
      if (s_valid === 1'b1) pulses++;
      if (s !== 4'b0001) s_moved++;
    end
    sw_in = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (s_valid === 1'b1) pulses++;
      if (s !== 4'b0001) s_moved++;
    end
    check({name, " pulses"}, pulses, 0);
    check({name, " s_moved"}, s_moved, 0);
  endtask

  initial begin
    int pulses;
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    sw_in  = 4'b1010;
    btn_in = 1'b1;

    vecs[0] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 0, 1'b0};
    vecs[1] = '{4'b0001, 1'b0, 4'b0001, 1'b0, 1, 1'b0};
    vecs[2] = '{4'b0011, 1'b0, 4'b0011, 1'b0, 1, 1'b0};
    vecs[3] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 1, 1'b0};
    vecs[4] = '{4'b0110, 1'b0, 4'b0110, 1'b0, 1, 1'b0};
    vecs[5] = '{4'b0110, 1'b1, 4'b0110, 1'b1, 0, 1'b0};
    vecs[6] = '{4'b0111, 1'b0, 4'b0111, 1'b0, 1, 1'b0};
    vecs[7] = '{4'b1000, 1'b0, 4'b1000, 1'b0, 1, ERR_ON};
    vecs[8] = '{4'b1001, 1'b0, 4'b1001, 1'b0, 1, ERR_ON};
    vecs[9] = '{4'b0001, 1'b0, 4'b0001, 1'b0, 1, ERR_ON};

    // Reset with nonzero inputs, then the first commit after release.
    for (int k = 0; k < 3; k++) tick();
    check("rst s", int'(s), 0);
    check("rst bot", int'(bot), 0);
    check("rst s_valid", int'(s_valid), 0);
    check("rst gray_err", int'(gray_err), 0);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (s_valid === 1'b1) pulses++;
      if (k == 6) check("rel s_edge6", int'(s), 0);
      if (k == 7) begin
        check("rel s_edge7", int'(s), 4'b1010);
        check("rel valid_edge7", int'(s_valid), 1);
        check("rel bot_edge7", int'(bot), 1);
      end
      if (k == 8) check("rel valid_edge8", int'(s_valid), 0);
    end
    check("rel pulses", pulses, 1);
    check("rel gray_err", int'(gray_err), int'(ERR_ON));

    // Clean restart from all-zero for the table walk.
    rst_n  = 1'b0;
    sw_in  = 4'b0000;
    btn_in = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    cur_s   = 4'b0000;
    cur_bot = 1'b0;
    check("rst2 gray_err", int'(gray_err), 0);

    for (int i = 0; i < 10; i++) apply_vec(i, vecs[i]);

    // 3 cycles is well short; 4 is the longest excursion that must not commit.
    glitch("glitch3", 3);
    glitch("glitch4", 4);

    // Reset at edge 4 of a pending 0001 -> 0110 debounce.
    sw_in = 4'b0110;
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1'b0;
    tick();
    check("mid s", int'(s), 0);
    check("mid s_valid", int'(s_valid), 0);
    check("mid gray_err", int'(gray_err), 0);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (s_valid === 1'b1) pulses++;
      if (k == 6) check("mid s_edge6", int'(s), 0);
      if (k == 7) begin
        check("mid s_edge7", int'(s), 4'b0110);
        check("mid valid_edge7", int'(s_valid), 1);
      end
    end
    check("mid pulses", pulses, 1);
    check("mid gray_err_after", int'(gray_err), int'(ERR_ON));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_input_sync.md
Name: gray_input_sync

Overview:
- Front-end stage that feeds the Gray-to-7-segment display decoder.
- Takes the raw 4 Gray-code switches and the digit-select button from the board.
- Synchronises each input, debounces it, and presents stable values on s[3:0] and bot.
- Pulses s_valid when a new Gray code is committed, and optionally flags input sequences that are not valid Gray steps.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised cycles required before a value is committed. Must be >= 2. Use 4 in simulation; board builds override it (e.g. 270000 at 27 MHz).
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1: width of each debounce counter (derived; not overridden).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- sw_in  in  4  raw asynchronous Gray-code switches.
- btn_in  in  1  raw asynchronous digit-select button.
- s  out  4  debounced Gray code, driven to the decoder's s input.
- bot  out  1  debounced button level, driven to the decoder's bot input.
- s_valid  out  1  one-cycle pulse on each commit of a new s value.
- gray_err  out  1  sticky flag: a committed s differed from the previous s in more than one bit.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous, active-low, and sampled on the rising edge of clk.
  - While rst_n=0, on each edge: s=0, bot=0, s_valid=0, gray_err=0, sync flops=0, candidate registers=0, counters=0.
  - Reset asserted mid-debounce discards the pending candidate. No commit occurs on the reset edge.
- Synchronisation:
  - Two-flop synchroniser on each of the 5 inputs. sw_sync is the 4-bit output; btn_sync is the 1-bit output.
- Switch-bus debounce (the 4 bits are debounced as one group):
  - cand_sw register and cnt_sw counter.
  - If sw_sync != cand_sw: cand_sw <= sw_sync and cnt_sw <= 0. Any bit toggle restarts the count.
  - Else if cnt_sw < DEBOUNCE_CYCLES-1: cnt_sw increments.
  - Else (saturated, stable): if cand_sw != s, then s <= cand_sw and s_valid <= 1 for exactly one cycle. Otherwise hold.
  - s_valid is 0 in every other cycle. A stable input never re-pulses.
- Latency:
  - An input change held steady appears on s at the (DEBOUNCE_CYCLES+3)th rising edge after the edge where sw_in is first sampled. This is 7 edges for DEBOUNCE_CYCLES=4.
  - s_valid rises on the same edge that s changes.
- Glitch rejection:
  - A change lasting fewer than DEBOUNCE_CYCLES+1 synchronised cycles never commits.
  - A bounce that returns to the current s commits nothing and produces no s_valid.
- Button debounce:
  - Identical structure, with its own cand_btn and cnt_btn, committing to bot.
  - No valid pulse for the button. bot is a level, not a toggle.
  - The button and switch paths are independent. Simultaneous changes on both debounce and commit in parallel.
- gray_err:
  - Set on a commit edge when popcount(s_old XOR cand_sw) > 1.
  - Once set, it stays 1 until reset.
  - The first commit after reset compares against s=0.
- Output timing: all outputs are registered. No combinational path from the inputs to the outputs.

Optional Feature:
- Macro: GRAY_CHECK_EN.
- Defined: the gray_err logic is implemented as described above.
- Undefined: the popcount/compare logic is omitted and gray_err is tied to 0. The port remains present so the decoder-level top needs no change.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with sw_in=4'b1010 and btn_in=1 -> s=0, bot=0, s_valid=0, gray_err=0. After release, s=4'b1010 at edge 7 with a one-cycle s_valid; gray_err=1 (2 bits changed from 0, macro on).
- Gray walk: with DEBOUNCE_CYCLES=4, step sw_in through 0000, 0001, 0011, 0010, 0110, holding each for 10 cycles.
  - Each s update occurs 7 edges after the change.
  - Exactly one s_valid pulse per step.
  - gray_err stays 0.
- Glitch rejection: s=0001 stable, then sw_in=0011 for 3 cycles and back to 0001 -> s stays 0001, no s_valid.
- Non-Gray jump: 0001 -> 1110 stable. Behaviour differs by macro:
  - GRAY_CHECK_EN defined: s=1110, s_valid pulse, gray_err=1 and it stays 1 through later valid steps.
  - GRAY_CHECK_EN undefined: gray_err=0.
- Button path:
  - btn_in 0->1 stable -> bot=1 at edge 7, s unchanged, no s_valid.
  - A simultaneous sw_in change commits on the same edge.
- Reset mid-debounce: change sw_in, assert rst_n=0 at edge 4 for 1 cycle -> s=0 and no s_valid from the aborted candidate. With the input held, a fresh commit occurs 7 edges after release.
